// File: rtl/spi_rx_pkg.sv
// Shared types and defaults for the SPI mode-0 receive slice.
package spi_rx_pkg;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_SYNC_STAGES = 2;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE   = 1'b0;
  localparam state_t ST_ACTIVE = 1'b1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_slave_rx_if.sv
// SPI pins plus receive-side strobes; master drives the pins, slave is the receiver.
interface spi_slave_rx_if #(parameter int DATA_W = spi_rx_pkg::DEF_DATA_W);

  logic              spi_sclk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              frame_start;
  logic              frame_end;
  logic              frame_err;
  logic [7:0]        byte_cnt;

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi,
    input  rx_data, rx_valid, frame_start, frame_end, frame_err, byte_cnt
  );

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi,
    output rx_data, rx_valid, frame_start, frame_end, frame_err, byte_cnt
  );

endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with registered one-cycle rise/fall detect.
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_LVL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Reset to the idle line level so release with an idle line shows no edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_LVL}};
      prev_q <= RST_LVL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall   <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign lvl = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 receive slave: oversampled pins, MSB-first word assembly, frame strobes.
module spi_slave_rx
  import spi_rx_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input logic            clk,
  input logic            rst,
  spi_slave_rx_if.slave  bus
);

  localparam int             BCW      = $clog2(DATA_W);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_LVL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(bus.spi_sclk),
    .lvl(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_LVL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .din(bus.spi_cs_n),
    .lvl(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  logic unused_sclk;
  assign unused_sclk = sclk_lvl ^ sclk_fall;

  // mosi gets one extra flop so it lines up with the registered sclk rise.
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   mosi_q;
  logic [SYNC_STAGES-1:0] warm;
  logic                   cs_armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_sync <= '0;
      mosi_q    <= 1'b0;
      warm      <= '0;
      cs_armed  <= 1'b0;
    end else begin
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      mosi_q    <= mosi_sync[SYNC_STAGES-1];
      warm      <= {warm[SYNC_STAGES-2:0], 1'b1};
      // A frame may only open after a genuine (post-reset) high cs_n sample.
      cs_armed  <= cs_armed | (warm[SYNC_STAGES-1] & cs_lvl);
    end
  end

  state_t            state;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] rx_data_q;
  logic [BCW-1:0]    bit_cnt;
  logic [7:0]        byte_cnt_q;
  logic              vld_p, fs_p, fe_p, err_p;
  logic              rx_valid_q, frame_start_q, frame_end_q, frame_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      shift_q       <= '0;
      rx_data_q     <= '0;
      bit_cnt       <= '0;
      byte_cnt_q    <= '0;
      vld_p         <= 1'b0;
      fs_p          <= 1'b0;
      fe_p          <= 1'b0;
      err_p         <= 1'b0;
      rx_valid_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      vld_p         <= 1'b0;
      fs_p          <= 1'b0;
      fe_p          <= 1'b0;
      err_p         <= 1'b0;
      rx_valid_q    <= vld_p;
      frame_start_q <= fs_p;
      frame_end_q   <= fe_p;
      frame_err_q   <= err_p;
      case (state)
        ST_IDLE: begin
          if (cs_fall && cs_armed) begin
            state      <= ST_ACTIVE;
            bit_cnt    <= '0;
            byte_cnt_q <= '0;
            fs_p       <= 1'b1;
          end
        end
        default: begin
          // cs_n rise takes priority over a coincident sclk rise.
          if (cs_rise) begin
            state <= ST_IDLE;
            fe_p  <= 1'b1;
            err_p <= (bit_cnt != '0);
          end else if (sclk_rise) begin
            shift_q <= {shift_q[DATA_W-2:0], mosi_q};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt    <= '0;
              rx_data_q  <= {shift_q[DATA_W-2:0], mosi_q};
              vld_p      <= 1'b1;
              byte_cnt_q <= sat_inc8(byte_cnt_q);
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end
        end
      endcase
    end
  end

  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_end   = frame_end_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.byte_cnt    = byte_cnt_q;

endmodule
